// File: rtl/alu_seq.sv
// ============================================================================
// Module  : alu_seq
// Brief   : clocked ALU with single-cycle ops and an iterative shift-add MUL
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int WIDTH     = 8,
    parameter int IMM_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           opcode,
    input  logic [IMM_WIDTH-1:0] a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     data_out,
    output logic                 zflag,
    output logic                 c
);

    localparam int PW = WIDTH + IMM_WIDTH;
    localparam int CW = (IMM_WIDTH > 1) ? $clog2(IMM_WIDTH) : 1;

    localparam logic [2:0]    c_OP_ADD = 3'b000;
    localparam logic [2:0]    c_OP_SUB = 3'b001;
    localparam logic [2:0]    c_OP_AND = 3'b010;
    localparam logic [2:0]    c_OP_OR  = 3'b011;
    localparam logic [2:0]    c_OP_XOR = 3'b100;
    localparam logic [2:0]    c_OP_SHL = 3'b101;
    localparam logic [2:0]    c_OP_SHR = 3'b110;
    localparam logic [2:0]    c_OP_MUL = 3'b111;
    localparam logic [CW-1:0] c_LAST   = CW'(IMM_WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [IMM_WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]       r_b;
    logic [PW-1:0]          r_acc;
    logic [CW-1:0]          r_cnt;

    logic [WIDTH-1:0]       w_a_ext;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [WIDTH:0]         w_shl;
    logic [WIDTH:0]         w_shr;
    logic [WIDTH-1:0]       w_res;
    logic                   w_res_c;
    logic [PW-1:0]          w_addend;
    logic [PW-1:0]          w_acc_next;
    logic                   w_last;

    // Shifts run one bit wider so the bit shifted out lands in a known slot;
    // out-of-range amounts naturally yield zero data and zero carry.
    always_comb begin
        w_a_ext = WIDTH'(a);
        w_sum   = {1'b0, b} + {1'b0, w_a_ext};
        w_diff  = {1'b0, b} + {1'b0, ~w_a_ext} + {{WIDTH{1'b0}}, 1'b1};
        w_shl   = {1'b0, b} << a;
        w_shr   = {b, 1'b0} >> a;
        w_res   = '0;
        w_res_c = 1'b0;
        case (opcode)
            c_OP_ADD: begin w_res = w_sum[WIDTH-1:0];  w_res_c = w_sum[WIDTH];  end
            c_OP_SUB: begin w_res = w_diff[WIDTH-1:0]; w_res_c = w_diff[WIDTH]; end
            c_OP_AND: w_res = b & w_a_ext;
            c_OP_OR:  w_res = b | w_a_ext;
            c_OP_XOR: w_res = b ^ w_a_ext;
            c_OP_SHL: begin w_res = w_shl[WIDTH-1:0]; w_res_c = w_shl[WIDTH]; end
            c_OP_SHR: begin w_res = w_shr[WIDTH:1];   w_res_c = w_shr[0];     end
            default:  ;
        endcase
    end

    always_comb begin
        w_addend   = r_a[r_cnt] ? ({{IMM_WIDTH{1'b0}}, r_b} << r_cnt) : '0;
        w_acc_next = r_acc + w_addend;
        w_last     = (r_cnt == c_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && (opcode == c_OP_MUL)) begin
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            done     <= 1'b0;
            data_out <= '0;
            zflag    <= 1'b1;
            c        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start && (opcode == c_OP_MUL)) begin
                    r_a   <= a;
                    r_b   <= b;
                    r_acc <= '0;
                    r_cnt <= '0;
                end else if (start) begin
                    data_out <= w_res;
                    zflag    <= (w_res == '0);
                    c        <= w_res_c;
                    done     <= 1'b1;
                end
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    data_out <= w_acc_next[WIDTH-1:0];
                    zflag    <= (w_acc_next[WIDTH-1:0] == '0);
                    c        <= |w_acc_next[PW-1:WIDTH];
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
// Module  : tb_alu_seq
// Brief   : directed self-checking bench for alu_seq (8/5 and 16/8 instances)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  opcode;
    logic [4:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  data_out;
    logic        zflag;
    logic        c;

    logic        start16;
    logic [2:0]  opcode16;
    logic [7:0]  a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [15:0] data_out16;
    logic        zflag16;
    logic        c16;

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(8), .IMM_WIDTH(5)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .a(a), .b(b),
        .busy(busy), .done(done), .data_out(data_out), .zflag(zflag), .c(c)
    );

    alu_seq #(.WIDTH(16), .IMM_WIDTH(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .opcode(opcode16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .data_out(data_out16), .zflag(zflag16), .c(c16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one 8-bit op at the negedge, then sample 1 time unit after the edge.
    task automatic issue8(input logic [2:0] op, input logic [4:0] av, input logic [7:0] bv);
        @(negedge clk);
        start = 1'b1; opcode = op; a = av; b = bv;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic op8(input string tag, input logic [2:0] op, input logic [4:0] av,
                       input logic [7:0] bv, input logic [7:0] ed, input logic ec, input logic ez);
        issue8(op, av, bv);
        check({tag, ".done"}, done, 1);
        check({tag, ".data"}, data_out, ed);
        check({tag, ".c"}, c, ec);
        check({tag, ".z"}, zflag, ez);
    endtask

    // Returns cycles until done (sampled after each edge), or -1 on timeout.
    task automatic wait_done(input bit wide, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #1;
            if (wide ? done16 : done) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int late_done;
        rst_n = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0;
        start16 = 1'b0; opcode16 = '0; a16 = '0; b16 = '0;
        #3 rst_n = 1'b0;
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.data", data_out, 0);
        check("rst.z", zflag, 1);
        check("rst.c", c, 0);
        check("rst.data16", data_out16, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op8("add", 3'b000, 5'd31, 8'hF0, 8'h0F, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("add.done_drop", done, 0);
        check("add.hold", data_out, 8'h0F);
        op8("sub_eq", 3'b001, 5'd5, 8'h05, 8'h00, 1'b1, 1'b1);
        op8("sub_brw", 3'b001, 5'd6, 8'h05, 8'hFF, 1'b0, 1'b0);
        op8("xor", 3'b100, 5'h1F, 8'hFF, 8'hE0, 1'b0, 1'b0);
        op8("shl3", 3'b101, 5'd3, 8'hA5, 8'h28, 1'b1, 1'b0);
        op8("shl8", 3'b101, 5'd8, 8'h81, 8'h00, 1'b1, 1'b1);
        op8("shr9", 3'b110, 5'd9, 8'hFF, 8'h00, 1'b0, 1'b1);
        op8("shr0", 3'b110, 5'd0, 8'h5A, 8'h5A, 1'b0, 1'b0);

        // MUL 20*13 = 0x104 with start pulses and operand noise while busy
        issue8(3'b111, 5'd20, 8'd13);
        check("mul.busy0", busy, 1);
        check("mul.done0", done, 0);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start  = (i < 5);
            opcode = 3'(i);
            a      = 5'($urandom);
            b      = 8'($urandom);
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            check("mul.busy", busy, 1);
        end
        start = 1'b0;
        check("mul.lat", lat, 5);
        check("mul.busy_done", busy, 0);
        check("mul.data", data_out, 8'h04);
        check("mul.c", c, 1);
        check("mul.z", zflag, 0);

        // back-to-back ADD, AND, OR, then MUL in the last done cycle
        @(negedge clk);
        start = 1'b1; opcode = 3'b000; a = 5'd1; b = 8'd2;
        @(posedge clk); #1;
        check("b2b.add.done", done, 1);
        check("b2b.add", data_out, 8'h03);
        opcode = 3'b010; a = 5'h0F; b = 8'h3C;
        @(posedge clk); #1;
        check("b2b.and.done", done, 1);
        check("b2b.and", data_out, 8'h0C);
        opcode = 3'b011; a = 5'h10; b = 8'h01;
        @(posedge clk); #1;
        check("b2b.or.done", done, 1);
        check("b2b.or", data_out, 8'h11);
        opcode = 3'b111; a = 5'd3; b = 8'd7;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b.mul.busy", busy, 1);
        check("b2b.mul.done", done, 0);
        wait_done(1'b0, 20, lat);
        check("b2b.mul.lat", lat, 5);
        check("b2b.mul.data", data_out, 8'h15);
        check("b2b.mul.c", c, 0);

        // reset in the middle of a multiply
        issue8(3'b111, 5'd20, 8'd13);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mrst.busy", busy, 0);
        check("mrst.done", done, 0);
        check("mrst.data", data_out, 0);
        check("mrst.z", zflag, 1);
        check("mrst.c", c, 0);
        @(negedge clk);
        rst_n = 1'b1;
        late_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) late_done++;
        end
        check("mrst.no_late", late_done, 0);
        op8("post_rst_add", 3'b000, 5'd1, 8'd1, 8'h02, 1'b0, 1'b0);

        // 16/8 instance
        @(negedge clk);
        start16 = 1'b1; opcode16 = 3'b111; a16 = 8'd255; b16 = 16'h0101;
        @(posedge clk); #1;
        start16 = 1'b0;
        check("w16.mul.busy", busy16, 1);
        wait_done(1'b1, 30, lat);
        check("w16.mul.lat", lat, 8);
        check("w16.mul.data", data_out16, 16'hFFFF);
        check("w16.mul.c", c16, 0);
        @(negedge clk);
        start16 = 1'b1; opcode16 = 3'b001; a16 = 8'd1; b16 = 16'h0000;
        @(posedge clk); #1;
        start16 = 1'b0;
        check("w16.sub.done", done16, 1);
        check("w16.sub.data", data_out16, 16'hFFFF);
        check("w16.sub.c", c16, 0);
        check("w16.sub.z", zflag16, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the 8-bit add/sub ALU in the datapath. It executes add, subtract, bitwise logic and shifts in one cycle, and an iterative shift-add multiply over the immediate operand. Results and flags sit in output registers, and a start/busy/done handshake connects the block to the control unit. It occupies the ALU slot in the datapath: operand `a` comes from the instruction immediate field, operand `b` from the register file.

## Interface
Parameters:
- `WIDTH`, default 8: datapath width of `b` and `data_out`; must be ≥ 2.
- `IMM_WIDTH`, default 5: width of immediate operand `a`; must be ≤ `WIDTH`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request an operation; sampled only in IDLE.
- `opcode` input 3: operation select, sampled with `start`.
- `a` input `IMM_WIDTH`: immediate operand, zero-extended to `WIDTH`.
- `b` input `WIDTH`: register operand.
- `busy` output 1: high while a multiply is iterating.
- `done` output 1: one-cycle pulse when the results are updated.
- `data_out` output `WIDTH`: registered result.
- `zflag` output 1: registered, `data_out == 0`.
- `c` output 1: registered carry, no-borrow or overflow (see Operation).

## Operation
- Opcode map:
  - 000 ADD: `b + a`.
  - 001 SUB: `b + ~a + 1`, i.e. `b - a`.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: `b << a`.
  - 110 SHR: logical `b >> a`.
  - 111 MUL: `b * a`.
- Operand `a` is zero-extended to `WIDTH` for every op. The shift amount is the full value of `a`.
- Rules for `c`:
  - ADD: carry out of bit `WIDTH-1`.
  - SUB: carry out of `b + ~a + 1`, so 1 means no borrow (`b >= a`).
  - AND, OR, XOR: 0.
  - SHL: `b[WIDTH-amt]` if 1 ≤ amt ≤ `WIDTH`, else 0.
  - SHR: `b[amt-1]` if 1 ≤ amt ≤ `WIDTH`, else 0.
  - MUL: OR of product bits `[WIDTH+IMM_WIDTH-1:WIDTH]` (overflow).
- Shift amount ≥ `WIDTH` gives `data_out` = 0. Shift amount 0 passes `b` through with `c` = 0.
- MUL uses shift-add: one bit of `a`, LSB first, per cycle. It runs for exactly `IMM_WIDTH` iterations into an internal `WIDTH+IMM_WIDTH` accumulator. `data_out` takes the low `WIDTH` bits.
- `zflag` is computed from the value being written to `data_out`, in the same edge.
- `data_out`, `zflag` and `c` change only on a `done` edge; they hold otherwise.
- State machine:
  - IDLE: `busy` = 0.
    - `start` with a non-MUL opcode: registers the result at that edge, pulses `done`, stays in IDLE.
    - `start` with MUL: latches `a`, `b`, clears the accumulator and iteration counter, goes to MUL.
  - MUL: `busy` = 1. Each edge adds `b << k` when `a[k]` = 1 and increments k. On the edge completing iteration `IMM_WIDTH-1`, writes the results, pulses `done`, returns to IDLE.
- `start` while in MUL is ignored: no queueing and no effect on the operation in flight.
- Changes to `a`, `b` or `opcode` during MUL do not affect the result, because the operands are latched.

## Timing
- Reset (`rst_n` low, immediate, asynchronous):
  - state IDLE;
  - `busy` = 0, `done` = 0, `data_out` = 0, `zflag` = 1, `c` = 0;
  - accumulator and counter cleared.
- Single-cycle ops: `start` sampled at edge E0; results valid and `done` = 1 in the cycle after E0.
- Back-to-back single-cycle ops can issue every cycle. `done` then stays high on consecutive cycles, once per operation.
- MUL: `start` at E0; `busy` = 1 from E0 through E`IMM_WIDTH`; results written and `done` = 1 at E`IMM_WIDTH` (latency `IMM_WIDTH` cycles). `busy` is 0 in the cycle where `done` = 1.
- A new `start` is accepted in the same cycle that `done` is high.
- Reset asserted mid-MUL aborts the operation: all outputs return to their reset values and no `done` is issued.

## Test plan
- ADD and SUB (`WIDTH`=8, `IMM_WIDTH`=5):
  - ADD a=31, b=0xF0 → `data_out`=0x0F, `c`=1, `zflag`=0, `done` one cycle after `start`.
  - SUB a=5, b=5 → 0x00, `c`=1, `zflag`=1.
  - SUB a=6, b=5 → 0xFF, `c`=0.
- Logic and shifts:
  - XOR a=0x1F, b=0xFF → 0xE0, `c`=0.
  - SHL a=3, b=0xA5 → 0x28, `c`=1.
  - SHL a=8, b=0x81 → 0x00, `c`=1, `zflag`=1.
  - SHR a=9, b=0xFF → 0x00, `c`=0, `zflag`=1.
- MUL a=20, b=13:
  - `busy` high for 5 cycles, `done` exactly 5 cycles after `start`, `data_out`=0x04, `c`=1.
  - Extra `start` pulses and operand changes during `busy` have no effect.
- Back-to-back issue: ADD, AND, OR on three consecutive cycles → three consecutive `done` pulses with correct results each cycle; a MUL issued in the same cycle as the last `done` is accepted.
- Reset mid-MUL: drop `rst_n` after iteration 2 → `busy`=0, `done`=0, `data_out`=0, `zflag`=1, `c`=0 immediately, with no late `done`. After release, ADD a=1, b=1 → 0x02.
- Parameter sweep `WIDTH`=16, `IMM_WIDTH`=8: MUL a=255, b=0x0101 → 0xFFFF, `c`=0, latency 8; SUB a=1, b=0 → 0xFFFF, `c`=0.
